// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader. The slot geometry defaults are
// the same values used by the instruction memory and the OS memory map.
// The output flag decode lives here so the FSM can register its strobes as
// a function of the state being entered.
// ---------------------------------------------------------------------------
package prog_loader_pkg;

    localparam int DEF_BLOCK_SIZE = 200;
    localparam int DEF_NUM_SLOTS  = 10;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_TIMEOUT    = 64;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        WAIT,
        WRITE,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        logic busy;
        logic hd_rd_req;
        logic imem_we;
        logic done;
        logic error;
    } flags_t;

    // Moore output pattern associated with each state.
    function automatic flags_t flags_for(state_t s);
        flags_t f;
        f.busy      = (s != IDLE);
        f.hd_rd_req = (s == REQ);
        f.imem_we   = (s == WRITE);
        f.done      = (s == DONE);
        f.error     = (s == ERR);
        return f;
    endfunction

endpackage

// File: rtl/prog_loader_addr_gen.sv
// ---------------------------------------------------------------------------
// prog_loader_addr_gen
// Word index counter for one load plus the two address adders derived from
// it: the HD source address and the instruction-memory destination address.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   clear          zero the index (new load accepted)
//   advance        step the index (one word written)
//   proc_id        latched slot index
//   hd_base        latched first HD word address
//   idx            current word index within the load
//   hd_addr        hd_base + idx
//   imem_addr      proc_id * BLOCK_SIZE + idx
// ---------------------------------------------------------------------------
module prog_loader_addr_gen
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [7:0]        proc_id,
    input  logic [ADDR_W-1:0] hd_base,
    output logic [ADDR_W-1:0] idx,
    output logic [ADDR_W-1:0] hd_addr,
    output logic [ADDR_W-1:0] imem_addr
);

    logic [ADDR_W-1:0] slot_base;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= idx + ADDR_W'(1);
        end
    end

    // Constant multiply; the CHECK bound keeps idx inside the slot, so the
    // sum never reaches into the next slot.
    assign slot_base = ADDR_W'(proc_id) * ADDR_W'(BLOCK_SIZE);
    assign hd_addr   = hd_base + idx;
    assign imem_addr = slot_base + idx;

endmodule

// File: rtl/prog_loader_ctrl.sv
// ---------------------------------------------------------------------------
// prog_loader_ctrl
// Copies one program image from the HD word interface into the instruction
// memory slot of a process, using a single start/done handshake.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start                 load request, sampled only in IDLE
//   proc_id, hd_base,     slot index, HD source address and word count,
//   length                latched when start is accepted
//   hd_rd_req, hd_addr    one-cycle HD read strobe and its address
//   hd_rd_valid, hd_data  HD response, honoured only while waiting
//   imem_we, imem_addr,   one-cycle instruction-memory write
//   imem_wdata
//   busy                  high in every state except IDLE
//   done, error           one-cycle completion / rejection-or-timeout pulses
//   words_loaded          words written by the current or last load
// ---------------------------------------------------------------------------
module prog_loader_ctrl
    import prog_loader_pkg::*;
#(
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        proc_id,
    input  logic [ADDR_W-1:0] hd_base,
    input  logic [ADDR_W-1:0] length,
    output logic              hd_rd_req,
    output logic [ADDR_W-1:0] hd_addr,
    input  logic              hd_rd_valid,
    input  logic [DATA_W-1:0] hd_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t            state;
    flags_t            flags;
    logic [7:0]        proc_id_q;
    logic [ADDR_W-1:0] hd_base_q;
    logic [ADDR_W-1:0] length_q;
    logic [DATA_W-1:0] wdata_q;
    logic [TW-1:0]     tcnt;
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              advance;

    assign accept  = (state == IDLE) && start;
    assign advance = (state == WRITE);

    prog_loader_addr_gen #(
        .ADDR_W     (ADDR_W),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .clear     (accept),
        .advance   (advance),
        .proc_id   (proc_id_q),
        .hd_base   (hd_base_q),
        .idx       (idx),
        .hd_addr   (hd_addr),
        .imem_addr (imem_addr)
    );

    // Every transition also loads the strobe pattern of the target state, so
    // the outputs come straight from flops and match the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            flags        <= '0;
            proc_id_q    <= '0;
            hd_base_q    <= '0;
            length_q     <= '0;
            wdata_q      <= '0;
            tcnt         <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        proc_id_q    <= proc_id;
                        hd_base_q    <= hd_base;
                        length_q     <= length;
                        words_loaded <= '0;
                        state        <= CHECK;
                        flags        <= flags_for(CHECK);
                    end
                end
                CHECK: begin
                    if ((ADDR_W'(proc_id_q) >= ADDR_W'(NUM_SLOTS)) ||
                        (length_q > ADDR_W'(BLOCK_SIZE))) begin
                        state <= ERR;
                        flags <= flags_for(ERR);
                    end else if (length_q == '0) begin
                        state <= DONE;
                        flags <= flags_for(DONE);
                    end else begin
                        state <= REQ;
                        flags <= flags_for(REQ);
                    end
                end
                REQ: begin
                    tcnt  <= '0;
                    state <= WAIT;
                    flags <= flags_for(WAIT);
                end
                WAIT: begin
                    if (hd_rd_valid) begin
                        wdata_q <= hd_data;
                        state   <= WRITE;
                        flags   <= flags_for(WRITE);
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state <= ERR;
                        flags <= flags_for(ERR);
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + ADDR_W'(1);
                    if (idx + ADDR_W'(1) == length_q) begin
                        state <= DONE;
                        flags <= flags_for(DONE);
                    end else begin
                        state <= REQ;
                        flags <= flags_for(REQ);
                    end
                end
                DONE, ERR: begin
                    state <= IDLE;
                    flags <= flags_for(IDLE);
                end
                default: begin
                    state <= IDLE;
                    flags <= flags_for(IDLE);
                end
            endcase
        end
    end

    assign busy       = flags.busy;
    assign hd_rd_req  = flags.hd_rd_req;
    assign imem_we    = flags.imem_we;
    assign done       = flags.done;
    assign error      = flags.error;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prog_loader_ctrl
// Scoreboard bench for prog_loader_ctrl. Stimulus tasks push the expected HD
// reads, instruction-memory writes and end pulses; a negedge monitor pops
// and compares whenever the DUT raises a strobe. A small HD model answers
// read requests after a configurable latency.
// ---------------------------------------------------------------------------
module tb_prog_loader_ctrl;

    localparam int BS      = 200;
    localparam int TIMEOUT = 64;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  proc_id;
    logic [31:0] hd_base;
    logic [31:0] length;
    logic        hd_rd_req;
    logic [31:0] hd_addr;
    logic        hd_rd_valid;
    logic [31:0] hd_data;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] words_loaded;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [31:0] words;
    } end_t;

    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    end_t        exp_end[$];

    logic [31:0] hd_mem [0:4095];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // HD model controls
    int hd_limit = -1;
    bit hd_rand  = 0;
    bit hd_pend  = 0;
    int hd_wait  = 0;
    logic [31:0] hd_word;

    prog_loader_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .proc_id      (proc_id),
        .hd_base      (hd_base),
        .length       (length),
        .hd_rd_req    (hd_rd_req),
        .hd_addr      (hd_addr),
        .hd_rd_valid  (hd_rd_valid),
        .hd_data      (hd_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // HD model: a request seen in cycle r is answered with a one-cycle valid
    // in cycle r+1+extra, where extra is 0 or random 0..5.
    always @(negedge clock) begin
        hd_rd_valid = 1'b0;
        if (reset) begin
            hd_pend = 0;
        end else begin
            if (hd_pend) begin
                if (hd_wait == 0) begin
                    hd_rd_valid = 1'b1;
                    hd_data     = hd_word;
                    hd_pend     = 0;
                end else begin
                    hd_wait--;
                end
            end
            if (hd_rd_req && hd_limit != 0) begin
                hd_pend = 1;
                hd_wait = hd_rand ? int'($urandom_range(0, 5)) : 0;
                hd_word = hd_mem[hd_addr[11:0]];
                if (hd_limit > 0) hd_limit--;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clock) begin : monitor
        logic [31:0] ra;
        wr_t         w;
        end_t        e;
        if (hd_rd_req) begin
            tests++;
            if (exp_rd.size() == 0) begin
                fails++;
                $display("[TB] FAIL hd_read: unexpected read addr=%0d, none required", hd_addr);
            end else begin
                ra = exp_rd.pop_front();
                if (hd_addr !== ra) begin
                    fails++;
                    $display("[TB] FAIL hd_read: addr got %0d want %0d", hd_addr, ra);
                end
            end
        end
        if (imem_we) begin
            tests++;
            if (exp_wr.size() == 0) begin
                fails++;
                $display("[TB] FAIL imem_write: unexpected write addr=%0d data=%h", imem_addr, imem_wdata);
            end else begin
                w = exp_wr.pop_front();
                if (imem_addr !== w.addr || imem_wdata !== w.data) begin
                    fails++;
                    $display("[TB] FAIL imem_write: got addr=%0d data=%h want addr=%0d data=%h",
                             imem_addr, imem_wdata, w.addr, w.data);
                end
            end
        end
        if (done || error) begin
            tests++;
            if (done && error) begin
                fails++;
                $display("[TB] FAIL end_pulse: done and error both high");
            end else if (exp_end.size() == 0) begin
                fails++;
                $display("[TB] FAIL end_pulse: unexpected done=%0b error=%0b", done, error);
            end else begin
                e = exp_end.pop_front();
                if (error !== e.is_err) begin
                    fails++;
                    $display("[TB] FAIL end_kind: got error=%0b want error=%0b", error, e.is_err);
                end else if (e.cyc >= 0 && cyc != e.cyc) begin
                    fails++;
                    $display("[TB] FAIL end_cycle: got %0d want %0d", cyc, e.cyc);
                end else if (words_loaded !== e.words) begin
                    fails++;
                    $display("[TB] FAIL end_words: got %0d want %0d", words_loaded, e.words);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    // Issues one start pulse and pushes the expected activity. keep<0 pushes
    // the full load; keep>=0 pushes only that many words and no end pulse.
    // timed=1 also requires the end pulse at its exact cycle.
    task automatic applyStimulus(input int pid, input int base, input int len,
                                 input bit timed, input int keep);
        int   t0;
        int   n;
        wr_t  w;
        end_t e;
        @(negedge clock);
        t0      = cyc;
        proc_id = 8'(pid);
        hd_base = 32'(base);
        length  = 32'(len);
        start   = 1'b1;
        if (pid >= 10 || len > BS) begin
            e.is_err = 1; e.cyc = t0 + 2; e.words = 0;
            exp_end.push_back(e);
        end else begin
            n = (keep >= 0) ? keep : len;
            for (int i = 0; i < n; i++) begin
                exp_rd.push_back(32'(base + i));
                w.addr = 32'(pid * BS + i);
                w.data = hd_mem[base + i];
                exp_wr.push_back(w);
            end
            if (keep < 0) begin
                e.is_err = 0; e.cyc = timed ? t0 + 3 * len + 2 : -1; e.words = 32'(len);
                exp_end.push_back(e);
            end
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while ((busy || exp_end.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("[TB] FAIL %s_timeout: still busy after %0d cycles", name, n);
        end
        checkOutput({name, "_reads_left"}, 32'(exp_rd.size()), 0);
        checkOutput({name, "_writes_left"}, 32'(exp_wr.size()), 0);
        checkOutput({name, "_busy"}, {31'd0, busy}, 0);
        exp_rd.delete();
        exp_wr.delete();
        exp_end.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int nw;
        int n;
        wr_t  w;
        end_t e;

        for (int i = 0; i < 4096; i++) hd_mem[i] = $urandom;
        hd_mem[500] = 32'hA;
        hd_mem[501] = 32'hB;
        hd_mem[502] = 32'hC;

        reset   = 1'b1;
        start   = 1'b0;
        proc_id = '0;
        hd_base = '0;
        length  = '0;
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_strobes", {27'd0, hd_rd_req, imem_we, done, error, busy}, 0);
        checkOutput("rst_hd_addr", hd_addr, 0);
        checkOutput("rst_imem_addr", imem_addr, 0);
        checkOutput("rst_imem_wdata", imem_wdata, 0);
        checkOutput("rst_words", words_loaded, 0);
        reset = 1'b0;

        // Basic 3-word load
        applyStimulus(2, 500, 3, 1, -1);
        waitDrain("load3", 100);
        checkOutput("load3_words", words_loaded, 3);

        // Empty load
        applyStimulus(1, 0, 0, 1, -1);
        waitDrain("len0", 20);
        checkOutput("len0_words", words_loaded, 0);

        // Rejected loads
        applyStimulus(0, 0, 201, 1, -1);
        waitDrain("len201", 20);
        applyStimulus(10, 0, 3, 1, -1);
        waitDrain("pid10", 20);

        // HD stops answering after the first word
        hd_limit = 1;
        @(negedge clock);
        t0      = cyc;
        proc_id = 8'd0;
        hd_base = 32'd300;
        length  = 32'd2;
        start   = 1'b1;
        exp_rd.push_back(32'd300);
        exp_rd.push_back(32'd301);
        w.addr = 32'd0; w.data = hd_mem[300];
        exp_wr.push_back(w);
        e.is_err = 1; e.cyc = t0 + 5 + TIMEOUT + 1; e.words = 32'd1;
        exp_end.push_back(e);
        @(negedge clock);
        start = 1'b0;
        waitDrain("timeout", 200);
        checkOutput("timeout_words", words_loaded, 1);
        hd_limit = -1;

        // Start while busy is ignored
        applyStimulus(0, 100, 5, 1, -1);
        repeat (4) @(negedge clock);
        proc_id = 8'd4;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        waitDrain("ignore_start", 100);
        checkOutput("ignore_start_words", words_loaded, 5);

        // Reset in the middle of a load
        applyStimulus(3, 200, 5, 1, 2);
        nw = 0;
        n  = 0;
        while (nw < 2 && n < 100) begin
            @(negedge clock);
            if (imem_we) nw++;
            n++;
        end
        checkOutput("midrst_writes_seen", 32'(nw), 2);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrst_busy", {31'd0, busy}, 0);
        checkOutput("midrst_strobes", {28'd0, hd_rd_req, imem_we, done, error}, 0);
        checkOutput("midrst_words", words_loaded, 0);
        checkOutput("midrst_reads_left", 32'(exp_rd.size()), 0);
        checkOutput("midrst_writes_left", 32'(exp_wr.size()), 0);
        reset = 1'b0;
        applyStimulus(3, 200, 5, 1, -1);
        waitDrain("after_rst", 100);
        checkOutput("after_rst_words", words_loaded, 5);

        // Full last slot with random HD latency
        hd_rand = 1;
        applyStimulus(9, 1000, 200, 0, -1);
        waitDrain("full_slot", 3000);
        checkOutput("full_slot_words", words_loaded, 200);
        hd_rand = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
